// File: rtl/nios2_mult_cell_seq.sv
// nios2_mult_cell_seq
//
// Multi-cycle Nios II multiply cell. One SLICE_W-bit slice of src2 is
// multiplied by the extended src1 on each edge and added into a single
// accumulator. The low or high product word is returned for the four
// Nios II multiply ops. Both sides use valid/ready handshakes.
//
// Optional build macro: NIOS2_MULT_CELL_EARLY_OUT_EN
//   When defined, the cell finishes as soon as every src2 bit above the
//   slice just consumed is zero. This gives a latency of 1..N edges.
//   When undefined, the latency is always N edges and no zero-detect
//   logic is built.

module nios2_mult_cell_seq #(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [DATA_W-1:0] in_src1,
    input  logic [DATA_W-1:0] in_src2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              busy
);

    localparam int N     = DATA_W / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    // One bit of headroom above the 2*DATA_W product. All arithmetic is
    // modulo 2^ACC_W, which is enough because only the low 2*DATA_W bits
    // are ever returned.
    localparam int ACC_W = 2 * DATA_W + 1;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULXSS = 2'b01;
    localparam logic [1:0] OP_MULXSU = 2'b10;

    if ((DATA_W % SLICE_W) != 0 || SLICE_W < 4) begin : g_bad_params
        $error("nios2_mult_cell_seq: DATA_W must be a multiple of SLICE_W and SLICE_W >= 4");
    end

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t state, state_next;

    logic [1:0]        op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  count;

    logic [SLICE_W-1:0] slice;
    logic               top_slice;
    logic [SLICE_W:0]   slice_ext;
    logic [DATA_W:0]    src1_ext;
    logic [ACC_W-1:0]   a_wide;
    logic [ACC_W-1:0]   b_wide;
    logic [ACC_W-1:0]   prod;
    logic [ACC_W-1:0]   prod_shifted;
    logic [ACC_W-1:0]   acc_next;
    logic [DATA_W-1:0]  result_next;
    logic               last_step;
    int                 shamt;

    // Builds the partial product for the current slice and the next accumulator value.
    always_comb begin
        shamt     = int'(count) * SLICE_W;
        slice     = SLICE_W'(src2 >> shamt);
        top_slice = (int'(count) == N - 1);
        // Only the top slice of a signed multiplier carries a sign.
        slice_ext = {(top_slice && op == OP_MULXSS) ? slice[SLICE_W-1] : 1'b0, slice};
        src1_ext  = {(op == OP_MULXSS || op == OP_MULXSU) ? src1[DATA_W-1] : 1'b0, src1};
        // Sign-extending both factors to the accumulator width makes a plain
        // modular multiply give the correct two's-complement partial product.
        a_wide       = {{(ACC_W - DATA_W - 1){src1_ext[DATA_W]}}, src1_ext};
        b_wide       = {{(ACC_W - SLICE_W - 1){slice_ext[SLICE_W]}}, slice_ext};
        prod         = a_wide * b_wide;
        prod_shifted = prod << shamt;
        acc_next     = acc + prod_shifted;
        result_next  = (op == OP_MUL) ? acc_next[DATA_W-1:0] : acc_next[2*DATA_W-1:DATA_W];
`ifdef NIOS2_MULT_CELL_EARLY_OUT_EN
        // When the remaining multiplier bits are zero, the remaining slices add nothing.
        last_step = top_slice || ((src2 >> (shamt + SLICE_W)) == '0);
`else
        last_step = top_slice;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_next = MUL;
                end
            end
            MUL: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, accumulator, slice counter and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            op         <= 2'b00;
            src1       <= '0;
            src2       <= '0;
            acc        <= '0;
            count      <= '0;
            out_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op    <= in_op;
                        src1  <= in_src1;
                        src2  <= in_src2;
                        acc   <= '0;
                        count <= '0;
                    end
                end
                MUL: begin
                    acc   <= acc_next;
                    count <= count + CNT_W'(1);
                    if (last_step) begin
                        out_result <= result_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nios2_mult_cell_seq.sv
// Testbench for nios2_mult_cell_seq (DATA_W=32, SLICE_W=16).
// Runs a table of directed vectors, reset during an operation,
// back-pressure in DONE, and random traffic checked against a reference model.

module tb_nios2_mult_cell_seq;

    localparam int DATA_W  = 32;
    localparam int SLICE_W = 16;
    localparam int N       = DATA_W / SLICE_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        in_op;
    logic [DATA_W-1:0] in_src1;
    logic [DATA_W-1:0] in_src2;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_result;
    logic              busy;

    typedef struct {
        logic [1:0]        op;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [DATA_W-1:0] expected;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] result;
        int                latency;
        int                acceptCycle;
    } sb_t;

    sb_t sb[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cycle       = 0;

    logic              prevValid   = 1'b0;
    logic [DATA_W-1:0] heldResult  = '0;
    logic              forcedReady = 1'b1;
    logic              randomReady = 1'b0;

    nios2_mult_cell_seq #(
        .DATA_W (DATA_W),
        .SLICE_W(SLICE_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_src1   (in_src1),
        .in_src2   (in_src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_result(out_result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Consumer side: either a fixed level or random back-pressure.
    always @(posedge clk) begin
        #2;
        out_ready = randomReady ? ($urandom_range(0, 1) == 1) : forcedReady;
    end

    function automatic logic [DATA_W-1:0] refMul(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        logic [2*DATA_W-1:0] wa;
        logic [2*DATA_W-1:0] wb;
        logic [2*DATA_W-1:0] p;
        wa = (op == 2'b01 || op == 2'b10) ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        wb = (op == 2'b01) ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        p  = wa * wb;
        return (op == 2'b00) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
    endfunction

    function automatic int refLatency(input logic [DATA_W-1:0] b);
`ifdef NIOS2_MULT_CELL_EARLY_OUT_EN
        for (int k = 1; k < N; k++) begin
            if ((b >> (k * SLICE_W)) == '0) return k;
        end
`endif
        return (b == b) ? N : N;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one request (caller is just after a rising edge), waits for
    // acceptance and records the expected result and latency.
    task automatic applyStimulus(input logic [1:0] op, input logic [DATA_W-1:0] a,
                                 input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] expected);
        sb_t e;
        int  budget;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_valid = 1'b1;
        budget   = 0;
        @(negedge clk);
        while (!in_ready && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            checkOutput("accept timeout", 64'(in_ready), 64'd1);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.result      = expected;
            e.latency     = refLatency(b);
            e.acceptCycle = cycle;
            sb.push_back(e);
            in_valid = 1'b0;
            in_src1  = $urandom;
            in_src2  = $urandom;
            in_op    = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic waitDrain();
        int budget = 0;
        while (sb.size() > 0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (sb.size() > 0) begin
            checkOutput("drain timeout", 64'(sb.size()), 64'd0);
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    // Output monitor: latency on the rising out_valid, stability while
    // held, and the result at the completing handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (out_valid && !prevValid) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious out_valid", 64'(out_valid), 64'd0);
                end else begin
                    checkOutput("latency", 64'(cycle - sb[0].acceptCycle), 64'(sb[0].latency));
                end
            end
            if (out_valid && prevValid) begin
                checkOutput("result hold", 64'(out_result), 64'(heldResult));
            end
            if (out_valid && out_ready && sb.size() > 0) begin
                checkOutput("result", 64'(out_result), 64'(sb[0].result));
                void'(sb.pop_front());
            end
            heldResult = out_result;
        end
        prevValid = reset ? 1'b0 : out_valid;
    end

    vec_t vecs[12];

    initial begin
        int c0;
        int budget;
        logic [1:0]        rop;
        logic [DATA_W-1:0] ra;
        logic [DATA_W-1:0] rb;

        vecs = '{
            '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001},
            '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000},
            '{2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE},
            '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000},
            '{2'b11, 32'h80000000, 32'h80000000, 32'h40000000},
            '{2'b10, 32'h80000000, 32'h80000000, 32'hC0000000},
            '{2'b00, 32'h80000000, 32'h80000000, 32'h00000000},
            '{2'b00, 32'h12345678, 32'h00000003, 32'h369D0368},
            '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF},
            '{2'b11, 32'h00010000, 32'h00010000, 32'h00000001},
            '{2'b00, 32'h0000FFFF, 32'h00010001, 32'hFFFFFFFF}
        };

        reset    = 1'b1;
        in_valid = 1'b0;
        in_op    = 2'b00;
        in_src1  = '0;
        in_src2  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        checkOutput("reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset in_ready", 64'(in_ready), 64'd1);
        checkOutput("reset out_result", 64'(out_result), 64'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].op, vecs[i].src1, vecs[i].src2, vecs[i].expected);
            waitDrain();
        end

        // Reset while in MUL discards the operation.
        applyStimulus(2'b11, 32'h12345678, 32'hFFFF0000, 32'h0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        @(negedge clk);
        checkOutput("mid-op reset out_valid", 64'(out_valid), 64'd0);
        checkOutput("mid-op reset busy", 64'(busy), 64'd0);
        checkOutput("mid-op reset in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no output after reset", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;

        // Back-pressure in DONE while new requests are offered.
        forcedReady = 1'b0;
        applyStimulus(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        budget = 0;
        while (!out_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("backpressure out_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~i[0];
            in_src1  = $urandom;
            in_src2  = $urandom;
            @(negedge clk);
            checkOutput("held in_ready", 64'(in_ready), 64'd0);
            checkOutput("held out_valid", 64'(out_valid), 64'd1);
            checkOutput("held busy", 64'(busy), 64'd1);
        end
        @(posedge clk);
        #1;
        forcedReady = 1'b1;
        c0 = cycle;
        applyStimulus(2'b10, 32'hFFFFFFFE, 32'h00000005, refMul(2'b10, 32'hFFFFFFFE, 32'h00000005));
        if (sb.size() > 0) begin
            checkOutput("pending accept edge", 64'(sb[sb.size()-1].acceptCycle - c0), 64'd2);
        end
        waitDrain();

        // Random traffic with random consumer back-pressure.
        randomReady = 1'b1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = (i % 3 == 0) ? DATA_W'($urandom_range(0, 65535)) : DATA_W'($urandom);
            applyStimulus(rop, ra, rb, refMul(rop, ra, rb));
        end
        waitDrain();
        randomReady = 1'b0;
        repeat (3) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
